bus_burst_slave: RTL and testbench

Burst-capable memory slave on the shared system bus, directly upstream of the DMA engine.
- Answers the DMA's read bursts, and any master's single or burst accesses, from an internal word RAM.
- Drives dataValid/endTransaction/busError back to the master with a programmable first-word latency.
- Serves as the DMA's bring-up target and as the bench model of slow external memory.

---
 rtl/bus_burst_slave_if.sv | 47 ++++
 rtl/bus_burst_slave.sv | 173 +++++++++++++++++
 tb/tb_bus_burst_slave.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_burst_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_burst_slave_if
//  Description : Shared-bus signal bundle between a bus master and the burst
//                memory slave. The master drives the *In signals and the slave
//                drives the *Out signals.
//                  beginTransactionIn  - master starts a transaction
//                  addressDataIn[31:0] - address in the begin cycle, write data after
//                  readNotWriteIn      - 1 = read burst, 0 = write burst
//                  burstSizeIn[7:0]    - burst length minus one
//                  byteEnablesIn[3:0]  - write byte lanes
//                  dataValidIn         - write data word valid
//                  endTransactionIn    - master ends or aborts
//                  busyIn              - master stall on read data
//                  addressDataOut[31:0]- read data, 0 when not driving
//                  dataValidOut        - read word valid
//                  endTransactionOut   - slave ends read burst or error
//                  busErrorOut         - access error
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_burst_slave_if;
   logic        beginTransactionIn;
   logic [31:0] addressDataIn;
   logic        readNotWriteIn;
   logic [7:0]  burstSizeIn;
   logic [3:0]  byteEnablesIn;
   logic        dataValidIn;
   logic        endTransactionIn;
   logic        busyIn;
   logic [31:0] addressDataOut;
   logic        dataValidOut;
   logic        endTransactionOut;
   logic        busErrorOut;

   modport master (
      output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
             byteEnablesIn, dataValidIn, endTransactionIn, busyIn,
      input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
   );

   modport slave (
      input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
             byteEnablesIn, dataValidIn, endTransactionIn, busyIn,
      output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
   );
endinterface
`default_nettype wire

// File: rtl/bus_burst_slave.sv
`default_nettype none
// ============================================================================
//  Module      : bus_burst_slave
//  Description : Burst-capable word-RAM slave on the shared system bus.
//                Serves single and burst reads/writes with a programmable
//                first-word latency, byte-lane writes, window wrap-around,
//                master stall (busyIn) and master abort (endTransactionIn).
//  Ports       : clock - system clock (rising edge)
//                reset - synchronous, active-high
//                bus   - bus_burst_slave_if.slave bundle (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_burst_slave #(
   parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned WAIT_STATES  = 2
) (
   input wire logic          clock,
   input wire logic          reset,
   bus_burst_slave_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   // WAIT always lasts at least one cycle, so WAIT_STATES = 0 behaves like 1.
   localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_READ  = 3'd2,
      S_STALL = 3'd3,
      S_WRITE = 3'd4,
      S_END   = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [8:0]            count_q, count_d;
   logic [3:0]            wait_q, wait_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  dv_q, dv_d;
   logic                  end_q, end_d;
   logic                  err_q, err_d;

   logic [31:0]           mem [DEPTH];
   logic                  hit;
   logic                  mem_we;

   assign hit = (bus.addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);

   // Words past the programmed burst length are dropped (count already 0).
   assign mem_we = (state_q == S_WRITE) && bus.dataValidIn && (count_q != 9'd0) && !reset;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      wait_d  = wait_q;
      rdata_d = 32'd0;
      dv_d    = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.beginTransactionIn && hit) begin
               idx_d   = bus.addressDataIn[ADDR_WIDTH+1:2];
               count_d = 9'(bus.burstSizeIn) + 9'd1;
               wait_d  = 4'd0;
               if (bus.addressDataIn[1:0] != 2'b00) begin
                  state_d = S_ERROR;
               end else if (bus.readNotWriteIn) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WAIT: begin
            if (bus.endTransactionIn) begin
               state_d = S_IDLE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_READ;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end

         // READ and STALL both hand out a word in any cycle the master is not
         // busy; the word appears on the registered outputs one cycle later.
         S_READ, S_STALL: begin
            if (bus.endTransactionIn) begin
               state_d = S_IDLE;
            end else if (bus.busyIn) begin
               state_d = S_STALL;
            end else begin
               dv_d    = 1'b1;
               rdata_d = mem[idx_q];
               idx_d   = idx_q + ADDR_WIDTH'(1);
               count_d = count_q - 9'd1;
               state_d = (count_q == 9'd1) ? S_END : S_READ;
            end
         end

         S_WRITE: begin
            if (mem_we) begin
               idx_d   = idx_q + ADDR_WIDTH'(1);
               count_d = count_q - 9'd1;
            end
            if (bus.endTransactionIn) begin
               state_d = S_IDLE;
            end
         end

         S_END: begin
            end_d   = 1'b1;
            state_d = S_IDLE;
         end

         S_ERROR: begin
            end_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         count_q <= 9'd0;
         wait_q  <= 4'd0;
         rdata_q <= 32'd0;
         dv_q    <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         dv_q    <= dv_d;
         end_q   <= end_d;
         err_q   <= err_d;
      end
   end

   // RAM has no reset; contents survive a bus reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byteEnablesIn[b]) begin
               mem[idx_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
            end
         end
      end
   end

   assign bus.addressDataOut    = rdata_q;
   assign bus.dataValidOut      = dv_q;
   assign bus.endTransactionOut = end_q;
   assign bus.busErrorOut       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_burst_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_burst_slave
//  Description : Self-checking bench for bus_burst_slave. A word-array model
//                of the RAM plus cycle rules (first word at begin+2+WAIT,
//                one word per non-busy cycle, end one cycle after the last
//                word, abort/reset silence the outputs next cycle) predicts
//                every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_burst_slave;

   localparam logic [31:0] BASE = 32'h5000_0000;
   localparam int          WS   = 2;

   logic clock;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [31:0] ref_mem [1024];

   bus_burst_slave_if bus ();

   bus_burst_slave #(
      .BASE_ADDRESS (BASE),
      .ADDR_WIDTH   (10),
      .WAIT_STATES  (WS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic idle_inputs();
      reset                  = 1'b0;
      bus.beginTransactionIn = 1'b0;
      bus.addressDataIn      = 32'd0;
      bus.readNotWriteIn     = 1'b0;
      bus.burstSizeIn        = 8'd0;
      bus.byteEnablesIn      = 4'd0;
      bus.dataValidIn        = 1'b0;
      bus.endTransactionIn   = 1'b0;
      bus.busyIn             = 1'b0;
   endtask

   task automatic chk(input string tag, input logic e_dv, input logic [31:0] e_data,
                      input logic e_end, input logic e_err);
      n_cmp++;
      assert ({bus.dataValidOut, bus.endTransactionOut, bus.busErrorOut, bus.addressDataOut}
              === {e_dv, e_end, e_err, e_data})
      else begin
         n_fail++;
         $error("FAIL %s: observed dv=%b end=%b err=%b data=%h expected dv=%b end=%b err=%b data=%h",
                tag, bus.dataValidOut, bus.endTransactionOut, bus.busErrorOut, bus.addressDataOut,
                e_dv, e_end, e_err, e_data);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write burst; nwords may exceed bsz+1 to exercise discard of extra words.
   task automatic write_burst(input string tag, input logic [31:0] addr, input logic [7:0] bsz,
                              input int nwords, input logic [31:0] d0, input bit rnd_data,
                              input logic [3:0] be, input bit rnd_be, input int gap_pct);
      logic [9:0]  idx;
      int          rem;
      int          sent;
      logic [31:0] d;
      logic [3:0]  bew;
      @(negedge clock);
      idle_inputs();
      bus.beginTransactionIn = 1'b1;
      bus.addressDataIn      = addr;
      bus.readNotWriteIn     = 1'b0;
      bus.burstSizeIn        = bsz;
      idx  = addr[11:2];
      rem  = int'(bsz) + 1;
      sent = 0;
      for (int k = 0; k < 4000 && sent < nwords; k++) begin
         @(negedge clock);
         chk(tag, 1'b0, 32'd0, 1'b0, 1'b0);
         idle_inputs();
         if (int'($urandom_range(99)) >= gap_pct) begin
            d   = rnd_data ? $urandom : d0 + 32'(sent);
            bew = rnd_be ? 4'($urandom_range(15)) : be;
            bus.dataValidIn   = 1'b1;
            bus.addressDataIn = d;
            bus.byteEnablesIn = bew;
            if (rem > 0) begin
               for (int b = 0; b < 4; b++)
                  if (bew[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
               idx = idx + 10'd1;
               rem--;
            end
            sent++;
         end
      end
      @(negedge clock);
      chk(tag, 1'b0, 32'd0, 1'b0, 1'b0);
      idle_inputs();
      bus.endTransactionIn = 1'b1;
      @(negedge clock);
      chk(tag, 1'b0, 32'd0, 1'b0, 1'b0);
      idle_inputs();
   endtask

   // Read burst with random/forced busy, optional abort or reset at cycle k.
   task automatic read_burst(input string tag, input logic [31:0] addr, input logic [7:0] bsz,
                             input int busy_pct, input int busy_lo, input int busy_hi,
                             input int abort_at, input int reset_at,
                             output int first_k, output int end_k, output logic [31:0] first_data);
      logic [9:0]  idx;
      int          rem;
      int          tail;
      bit          fin;
      logic        e_dv, e_end, n_dv, n_end, busy;
      logic [31:0] e_data, n_data;
      first_k    = -1;
      end_k      = -1;
      first_data = 32'd0;
      @(negedge clock);
      idle_inputs();
      bus.beginTransactionIn = 1'b1;
      bus.addressDataIn      = addr;
      bus.readNotWriteIn     = 1'b1;
      bus.burstSizeIn        = bsz;
      idx = addr[11:2];
      rem = int'(bsz) + 1;
      tail = -1;
      fin  = 1'b0;
      e_dv = 1'b0; e_end = 1'b0; e_data = 32'd0;
      for (int k = 1; k < 1500; k++) begin
         @(negedge clock);
         chk(tag, e_dv, e_data, e_end, 1'b0);
         if (bus.dataValidOut === 1'b1 && first_k < 0) begin
            first_k    = k;
            first_data = bus.addressDataOut;
         end
         if (bus.endTransactionOut === 1'b1 && end_k < 0) end_k = k;
         idle_inputs();
         busy = (k >= busy_lo && k <= busy_hi) || (int'($urandom_range(99)) < busy_pct);
         bus.busyIn = busy;
         n_dv = 1'b0; n_end = 1'b0; n_data = 32'd0;
         if (tail == 0) begin
            fin = 1'b1;
            break;
         end else if (tail > 0) begin
            tail--;
         end else if (k == abort_at) begin
            bus.endTransactionIn = 1'b1;
            tail = 1;
         end else if (k == reset_at) begin
            reset = 1'b1;
            tail  = 1;
         end else begin
            // A begin while the slave is busy must be ignored.
            if ($urandom_range(9) == 0) begin
               bus.beginTransactionIn = 1'b1;
               bus.addressDataIn      = BASE | ($urandom & 32'h0000_0FFC);
               bus.readNotWriteIn     = 1'($urandom_range(1));
            end
            if (rem == 0) begin
               n_end = 1'b1;
               tail  = 1;
            end else if (k >= 1 + WS && !busy) begin
               n_dv   = 1'b1;
               n_data = ref_mem[idx];
               idx    = idx + 10'd1;
               rem--;
            end
         end
         e_dv = n_dv; e_end = n_end; e_data = n_data;
      end
      n_cmp++;
      assert (fin === 1'b1)
      else begin
         n_fail++;
         $error("FAIL %s_timeout: observed unfinished expected finished", tag);
      end
      idle_inputs();
   endtask

   task automatic err_access(input string tag, input logic [31:0] addr, input logic rnw);
      @(negedge clock);
      idle_inputs();
      bus.beginTransactionIn = 1'b1;
      bus.addressDataIn      = addr;
      bus.readNotWriteIn     = rnw;
      bus.burstSizeIn        = 8'd3;
      @(negedge clock); chk(tag, 1'b0, 32'd0, 1'b0, 1'b0); idle_inputs();
      @(negedge clock); chk(tag, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clock); chk(tag, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic miss(input string tag, input logic [31:0] addr);
      @(negedge clock);
      idle_inputs();
      bus.beginTransactionIn = 1'b1;
      bus.addressDataIn      = addr;
      bus.readNotWriteIn     = 1'b1;
      bus.burstSizeIn        = 8'd3;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         chk(tag, 1'b0, 32'd0, 1'b0, 1'b0);
         idle_inputs();
      end
   endtask

   initial begin
      int          fk, ek;
      logic [31:0] fd;
      logic [31:0] a, ra;
      int          bsz, extra;

      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("reset_state", 1'b0, 32'd0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++)
         write_burst("fill", BASE + 32'(i * 32'h400), 8'd255, 256, 32'd0, 1'b1, 4'hF, 1'b0, 10);

      write_burst("wr_a0", BASE + 32'h10, 8'd3, 4, 32'hA0, 1'b0, 4'hF, 1'b0, 0);
      read_burst("rd_a0", BASE + 32'h10, 8'd3, 0, -1, -1, -1, -1, fk, ek, fd);
      chk_int("rd_a0_first_cycle", fk, 4);
      chk_int("rd_a0_end_cycle", ek, 8);
      chk_word("rd_a0_first_data", fd, 32'hA0);

      write_burst("wr_wrap", BASE + 32'hFFC, 8'd1, 2, 32'd0, 1'b1, 4'hF, 1'b0, 0);
      read_burst("rd_wrap", BASE + 32'hFFC, 8'd1, 0, -1, -1, -1, -1, fk, ek, fd);
      chk_int("rd_wrap_end_cycle", ek, 6);

      err_access("err_rd", BASE + 32'h2, 1'b1);
      err_access("err_wr", BASE + 32'h3, 1'b0);

      read_burst("rd_busy", BASE + 32'h10, 8'd3, 0, 5, 6, -1, -1, fk, ek, fd);
      chk_int("rd_busy_end_cycle", ek, 10);

      write_burst("wr_ff", BASE + 32'h100, 8'd0, 1, 32'hFFFF_FFFF, 1'b0, 4'hF, 1'b0, 0);
      write_burst("wr_lane", BASE + 32'h100, 8'd0, 1, 32'h1122_3344, 1'b0, 4'b0101, 1'b0, 0);
      read_burst("rd_lane", BASE + 32'h100, 8'd0, 0, -1, -1, -1, -1, fk, ek, fd);
      chk_word("rd_lane_data", fd, 32'hFF22_FF44);

      read_burst("rd_abort", BASE + 32'h10, 8'd3, 0, -1, -1, 5, -1, fk, ek, fd);
      chk_int("rd_abort_no_end", ek, -1);
      read_burst("rd_reset", BASE + 32'h10, 8'd3, 0, -1, -1, -1, 6, fk, ek, fd);
      chk_int("rd_reset_no_end", ek, -1);
      read_burst("rd_after_reset", BASE + 32'h10, 8'd3, 20, -1, -1, -1, -1, fk, ek, fd);
      chk_word("rd_after_reset_data", fd, 32'hA0);

      miss("miss", 32'h6000_0000);

      for (int i = 0; i < 8; i++) begin
         a     = BASE | ($urandom & 32'h0000_0FFC);
         bsz   = int'($urandom_range(40));
         extra = int'($urandom_range(3));
         write_burst("rnd_wr", a, 8'(bsz), bsz + 1 + extra, 32'd0, 1'b1, 4'hF, 1'b1, 25);
         ra = BASE | ((a - 32'd8) & 32'h0000_0FFC);
         read_burst("rnd_rd", ra, 8'(bsz + 6), 30, -1, -1, -1, -1, fk, ek, fd);
      end

      write_burst("big_wr", BASE + 32'h800, 8'd255, 256, 32'd0, 1'b1, 4'hF, 1'b0, 10);
      read_burst("big_rd", BASE + 32'h800, 8'd255, 20, -1, -1, -1, -1, fk, ek, fd);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
